// File: rtl/fifo_uart_tx_drain.sv
// Drains the sample FIFO and sends each word MS byte first as 8N1 UART frames.
// Define TX_PARITY_EN to add an even-parity bit to every frame (8E1).
module fifo_uart_tx_drain #(
   parameter int DATA_W       = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              rd_en_i,
   input  logic              empty_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              fifo_rd_o,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       words_o
);

   localparam int         NBYTES   = DATA_W / 8;
   localparam int         CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

   typedef enum logic [2:0] {
      IDLE, POP, LOAD, START, DATA,
`ifdef TX_PARITY_EN
      PARITY,
`endif
      STOP, NEXT
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [1:0]        byte_idx;
   logic [DATA_W-1:0] word_reg;
   logic [7:0]        cur_byte;
   logic              bit_end;

   // The word is shifted left one byte per frame, so the byte on the wire is always the top one.
   assign cur_byte = word_reg[DATA_W-1 -: 8];
   assign bit_end  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         word_reg  <= '0;
         tx_o      <= 1'b1;
         fifo_rd_o <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         words_o   <= '0;
      end else begin
         fifo_rd_o <= 1'b0;
         done_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (!rd_en_i) begin
                  words_o <= '0;
               end else if (!empty_i) begin
                  state     <= POP;
                  fifo_rd_o <= 1'b1;
                  busy_o    <= 1'b1;
               end
            end
            POP: state <= LOAD;
            LOAD: begin
               word_reg <= data_i;
               byte_idx <= '0;
               cnt      <= '0;
               tx_o     <= 1'b0;
               state    <= START;
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx_o    <= cur_byte[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                     tx_o  <= ^cur_byte;
                     state <= PARITY;
`else
                     tx_o  <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_o    <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  tx_o  <= 1'b1;
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (byte_idx != LAST_IDX) begin
                     byte_idx <= byte_idx + 2'd1;
                     word_reg <= word_reg << 8;
                     tx_o     <= 1'b0;
                     state    <= START;
                  end else begin
                     // The word just finished means at least one word was sent in this drain.
                     words_o <= words_o + 16'd1;
                     busy_o  <= 1'b0;
                     done_o  <= empty_i;
                     state   <= NEXT;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            NEXT: begin
               if (!done_o && rd_en_i && !empty_i) begin
                  state     <= POP;
                  fifo_rd_o <= 1'b1;
                  busy_o    <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fifo_uart_tx_drain.md
Name: fifo_uart_tx_drain

Overview:
Reader side of the sample FIFO. While the control block holds read enabled, this block pops samples from the FIFO one at a time, splits each sample into bytes (MS byte first) and transmits them to the PC as 8N1 UART frames on tx_o. It sits between the FIFO read port and the board's UART TX pin, and reports when the FIFO has been fully drained.

Parameters:
DATA_W, 16, FIFO sample width in bits; multiple of 8, range 8..32; NBYTES = DATA_W/8.
CLKS_PER_BIT, 868, clk_i cycles per UART bit (100 MHz / 115200 baud); minimum 2.

Ports:
clk_i  input  1  system clock, all logic on rising edge.
rst_ni  input  1  asynchronous reset, active low.
rd_en_i  input  1  drain enable, driven by the control block's rd_o; level-sensitive.
empty_i  input  1  FIFO empty flag.
data_i  input  DATA_W  FIFO read data; valid exactly one cycle after a fifo_rd_o pulse.
fifo_rd_o  output  1  FIFO pop strobe; single-cycle pulse per word.
tx_o  output  1  UART serial line; idles high.
busy_o  output  1  high from the pop until the last stop bit of the word ends.
done_o  output  1  single-cycle pulse when the FIFO is found empty after at least one word in this drain.
words_o  output  16  count of words fully sent since the last IDLE entry with rd_en_i low; wraps at 0xFFFF to 0.

Behaviour:
- Reset (async assert, sync release): tx_o=1, fifo_rd_o=0, busy_o=0, done_o=0, words_o=0, FSM=IDLE, baud counter=0, byte index=0.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP, NEXT.
- IDLE: if rd_en_i=1 and empty_i=0, go to POP. If rd_en_i=0, clear words_o and the "sent-any" flag.
- POP: fifo_rd_o=1 for this cycle only; busy_o=1. Always go to LOAD.
- LOAD: shift register <= data_i; byte index=0; go to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits, LSB first; each bit is held for CLKS_PER_BIT cycles. The current byte is byte (NBYTES-1-index) of the latched word. After bit 7, go to STOP.
- STOP: tx_o=1 for CLKS_PER_BIT cycles. Then:
  - if index < NBYTES-1: index++, go to START (no idle gap between bytes).
  - else: go to NEXT.
- NEXT (one cycle): words_o++, busy_o=0. Then:
  - if rd_en_i=1 and empty_i=0: go to POP.
  - else if empty_i=1 and sent-any: done_o=1 this cycle, go to IDLE.
  - else: go to IDLE.
- First fifo_rd_o occurs 1 cycle after the IDLE condition is met. The tx_o start edge occurs 2 cycles after the pop.
- Word period = 2 + NBYTES*10*CLKS_PER_BIT + 1 cycles.
- rd_en_i deasserted mid-word: the current word completes all bytes; no further pop; no done_o unless the FIFO is empty.
- empty_i changing mid-word: ignored until NEXT.
- Never pop when empty_i=1. data_i is sampled only in LOAD.
- Reset asserted mid-frame: tx_o goes high immediately (async); the partial frame is aborted and the word is lost.
- The baud counter reloads at each state entry, so bit timing has no cumulative drift.

Optional Feature:
TX_PARITY_EN
- Defined: each frame carries an even-parity bit (XOR of the 8 data bits) between bit 7 and the stop bit, held for CLKS_PER_BIT cycles. Frames become 11 bits and the word period grows accordingly.
- Undefined: plain 8N1 with no parity state; logic is not synthesized.

Test Plan:
- Reset check (CLKS_PER_BIT=4, DATA_W=16): rst_ni low mid-DATA -> tx_o=1 within the same cycle; all outputs at reset values; no fifo_rd_o after release until rd_en_i=1.
- Single word: FIFO holds 0xA53C, rd_en_i=1 -> one fifo_rd_o pulse; tx_o sends byte 0xA5 then 0x3C (bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0), each bit 4 cycles; words_o=1; done_o pulses once in NEXT when empty_i=1.
- Burst of 4 words 0x0001..0x0004 -> exactly 4 pops spaced 83 cycles apart; back-to-back frames with no idle between bytes; words_o=4; one done_o.
- rd_en_i dropped during byte 0 of word 2 (FIFO not empty) -> word 2 finishes both bytes; no third pop; done_o=0; busy_o low after NEXT.
- Empty FIFO with rd_en_i=1 -> no fifo_rd_o, tx_o stays 1, done_o stays 0.
- With TX_PARITY_EN: data 0x0700 -> bytes 0x07 (parity 1) and 0x00 (parity 0); each frame is 44 cycles.
